// File: rtl/rs_syndrome.sv
// rtl/rs_syndrome.sv - RS(15,9) GF(16) syndrome calculator, one symbol per clock
//
// Purpose: accepts one received 60-bit RS(15,9) codeword per transaction and
//          computes the six syndromes S1..S6 (roots alpha^1..alpha^6, field
//          polynomial x^4+x+1) by Horner's rule, highest-degree symbol first.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   start request, sampled only while busy=0
//   datain   in   received codeword, [59:56]=c14 ... [3:0]=c0
//   busy     out  computation in progress (15 cycles)
//   rdy      out  one-cycle pulse, syndrom/err freshly updated
//   syndrom  out  packed syndromes, S1 at [3:0] ... S6 at [23:20]
//   err      out  any syndrome nonzero

module rs_syndrome #(
   parameter int CODE_WIDTH = 60,
   parameter int SYM_WIDTH  = 4,
   parameter int NSYN       = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [CODE_WIDTH-1:0]     datain,
   output logic                      busy,
   output logic                      rdy,
   output logic [NSYN*SYM_WIDTH-1:0] syndrom,
   output logic                      err
);

   localparam int NSTEP = CODE_WIDTH / SYM_WIDTH;
   localparam int SYNW  = NSYN * SYM_WIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            counter;
   logic [CODE_WIDTH-1:0] shreg;
   logic [SYNW-1:0]       acc;
   logic [SYNW-1:0]       acc_nxt;
   logic [SYNW-1:0]       syn_r;
   logic                  rdy_r;
   logic                  start;
   logic                  step;
   logic                  last;
   logic [SYM_WIDTH-1:0]  sym;

   // Multiply by alpha: shift left, fold the overflow back as x^4 = x + 1.
   function automatic logic [3:0] mul_alpha(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
   endfunction

   // Multiply by alpha^n for a constant n; unrolls into a pure XOR network.
   function automatic logic [3:0] mul_alpha_pow(input logic [3:0] x, input int n);
      logic [3:0] y;
      y = x;
      for (int k = 0; k < 6; k++) begin
         if (k < n) y = mul_alpha(y);
      end
      return y;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en)   state_nxt = CALC;
         CALC:    if (last) state_nxt = IDLE;
         default:           state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy  = (state == CALC);
      start = (state == IDLE) && en;
      step  = (state == CALC);
      last  = step && (counter == 4'(NSTEP - 1));
   end

   // Current symbol is always the top nibble; the register shifts left per step.
   assign sym = shreg[CODE_WIDTH-1 -: SYM_WIDTH];

   // One Horner step for every syndrome in parallel: A_j <- A_j*alpha^j ^ r.
   genvar j;
   generate
      for (j = 0; j < NSYN; j++) begin : g_horner
         assign acc_nxt[j*SYM_WIDTH +: SYM_WIDTH] =
            mul_alpha_pow(acc[j*SYM_WIDTH +: SYM_WIDTH], j + 1) ^ sym;
      end
   endgenerate

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter <= '0;
         shreg   <= '0;
         acc     <= '0;
         syn_r   <= '0;
         rdy_r   <= 1'b0;
      end else begin
         rdy_r <= last;
         if (start) begin
            shreg   <= datain;
            acc     <= '0;
            counter <= '0;
         end else if (step) begin
            shreg   <= {shreg[CODE_WIDTH-SYM_WIDTH-1:0], {SYM_WIDTH{1'b0}}};
            acc     <= acc_nxt;
            counter <= counter + 4'd1;
            // The last step's result goes straight to the output register,
            // so syndrom changes only on the result edge.
            if (last) syn_r <= acc_nxt;
         end
      end
   end

   assign rdy     = rdy_r;
   assign syndrom = syn_r;
   assign err     = |syn_r;

endmodule

// File: tb/tb_rs_syndrome.sv
// tb/tb_rs_syndrome.sv - self-checking bench for rs_syndrome

module tb_rs_syndrome;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [59:0] datain;
   logic        busy;
   logic        rdy;
   logic [23:0] syndrom;
   logic        err;

   int total = 0;
   int bad   = 0;

   rs_syndrome dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .datain  (datain),
      .busy    (busy),
      .rdy     (rdy),
      .syndrom (syndrom),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [59:0] din;
      logic [23:0] syn;
      logic        e;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference GF(16) multiply, shift-and-add over x^4+x+1.
   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] x;
      p = 4'h0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ x;
         x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
      end
      return p;
   endfunction

   // Systematic RS(15,9) encode: message on top, remainder of m(x)x^6 / g(x) below.
   function automatic logic [59:0] encode(input logic [35:0] msg);
      logic [3:0] g[7];
      logic [3:0] r[6];
      logic [3:0] root;
      logic [3:0] fb;
      logic [59:0] cw;
      for (int k = 0; k < 7; k++) g[k] = 4'h0;
      g[0] = 4'h1;
      root = 4'h1;
      for (int i = 1; i <= 6; i++) begin
         root = gf_mul(root, 4'h2);
         for (int k = 6; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
         g[0] = gf_mul(g[0], root);
      end
      for (int k = 0; k < 6; k++) r[k] = 4'h0;
      for (int s = 8; s >= 0; s--) begin
         fb = msg[s*4 +: 4] ^ r[5];
         for (int k = 5; k >= 1; k--) r[k] = r[k-1] ^ gf_mul(fb, g[k]);
         r[0] = gf_mul(fb, g[0]);
      end
      cw = '0;
      cw[59:24] = msg;
      for (int k = 0; k < 6; k++) cw[k*4 +: 4] = r[k];
      return cw;
   endfunction

   // Syndromes of a single-bit error at bit b: S_j = e * alpha^(j*p).
   function automatic logic [23:0] err_syn(input int b);
      logic [23:0] s;
      logic [3:0]  v;
      int          p;
      p = b / 4;
      for (int j = 1; j <= 6; j++) begin
         v = 4'(1 << (b % 4));
         for (int k = 0; k < j * p; k++) v = gf_mul(v, 4'h2);
         s[(j-1)*4 +: 4] = v;
      end
      return s;
   endfunction

   task automatic run_txn(input logic [59:0] d, input bit toggle,
                          output logic [23:0] syn, output logic e,
                          output int lat, output int bcnt, output logic rdy_after);
      @(negedge clk);
      datain = d;
      en     = 1'b1;
      lat    = 0;
      bcnt   = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) bcnt++;
         if (rdy) break;
         en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
         if (toggle) datain = 60'({$urandom(), $urandom()});
      end
      syn = syndrom;
      e   = err;
      en  = 1'b0;
      @(posedge clk);
      #1;
      rdy_after = rdy;
   endtask

   logic [23:0] syn;
   logic        e;
   int          lat;
   int          bcnt;
   logic        ra;
   logic [59:0] cw;

   initial begin
      vecs[0] = '{60'h0,  24'h000000, 1'b0};
      vecs[1] = '{60'h1,  24'h111111, 1'b1};
      vecs[2] = '{60'h10, 24'hC63842, 1'b1};
      cw = encode(36'h0);
      vecs[3] = '{cw, 24'h0, 1'b0};
      vecs[6] = '{cw ^ (60'h1 << 0), err_syn(0), 1'b1};
      cw = encode(36'hFFFFFFFFF);
      vecs[4] = '{cw, 24'h0, 1'b0};
      vecs[7] = '{cw ^ (60'h1 << 37), err_syn(37), 1'b1};
      cw = encode(36'h123456789);
      vecs[5] = '{cw, 24'h0, 1'b0};
      vecs[8] = '{cw ^ (60'h1 << 59), err_syn(59), 1'b1};

      rst_n  = 1'b0;
      en     = 1'b0;
      datain = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rdy", 64'(rdy), 64'd0);
      chk("reset_syn", 64'(syndrom), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].din, 1'b0, syn, e, lat, bcnt, ra);
         chk($sformatf("v%0d_latency", i), 64'(lat - 1), 64'd15);
         chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd15);
         chk($sformatf("v%0d_rdy_pulse", i), 64'(ra), 64'd0);
         chk($sformatf("v%0d_syn", i), 64'(syn), 64'(vecs[i].syn));
         chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].e));
      end

      // en held high: accepts only at edges 0 and 16; datain garbage otherwise.
      for (int ed = 0; ed < 32; ed++) begin
         @(negedge clk);
         en = 1'b1;
         if (ed == 0)       datain = 60'h1;
         else if (ed == 16) datain = 60'h10;
         else               datain = 60'hFEDCBA987654321 ^ 60'(ed);
         @(posedge clk);
         #1;
         chk($sformatf("hold_rdy_e%0d", ed), 64'(rdy), 64'((ed == 15) || (ed == 31)));
         chk($sformatf("hold_busy_e%0d", ed), 64'(busy), 64'((ed % 16) != 15));
         if (ed == 15) chk("hold_syn_first", 64'(syndrom), 64'h111111);
         if (ed == 31) chk("hold_syn_second", 64'(syndrom), 64'hC63842);
      end
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_idle_after", 64'(busy), 64'd0);

      // en and datain toggled randomly during busy must not disturb the result.
      run_txn(60'h10, 1'b1, syn, e, lat, bcnt, ra);
      chk("toggle_latency", 64'(lat - 1), 64'd15);
      chk("toggle_syn", 64'(syn), 64'hC63842);
      chk("toggle_err", 64'(e), 64'd1);

      // Asynchronous reset in the middle of CALC (after step 7).
      @(negedge clk);
      datain = 60'h123456789ABCDEF;
      en     = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("midrst_busy_before", 64'(busy), 64'd1);
      chk("midrst_syn_before", 64'(syndrom), 64'hC63842);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rdy", 64'(rdy), 64'd0);
      chk("midrst_syn", 64'(syndrom), 64'd0);
      chk("midrst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(60'h1, 1'b0, syn, e, lat, bcnt, ra);
      chk("postrst_latency", 64'(lat - 1), 64'd15);
      chk("postrst_syn", 64'(syn), 64'h111111);
      chk("postrst_err", 64'(e), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
